// File: rtl/yarp_lsu.sv
// Load/store unit: one memory access per instruction over a req/gnt/rvalid port.
// The core is stalled from accept until retire; loads are sign- or zero-extended.
module yarp_lsu #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              data_req_i,
  input  logic [1:0]        data_byte_i,
  input  logic              data_wr_i,
  input  logic              zero_extnd_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [XLEN-1:0]   wr_data_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,
  output logic              stall_o,
  output logic              rd_valid_o,
  output logic [XLEN-1:0]   rd_data_o,
  output logic              misaligned_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [1:0]        off_q, size_q;
  logic              wr_q, zext_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        be_q, be_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rd_data_q, load_ext;
  logic [XLEN-1:0]   shifted;
  logic              aligned, accept;

  always_comb begin
    aligned = 1'b1;
    be_d    = 4'b1111;
    wdata_d = wr_data_i;
    case (data_byte_i)
      2'b00: begin
        be_d    = 4'b0001 << addr_i[1:0];
        wdata_d = {4{wr_data_i[7:0]}};
      end
      2'b01: begin
        aligned = ~addr_i[0];
        be_d    = 4'b0011 << {addr_i[1], 1'b0};
        wdata_d = {2{wr_data_i[15:0]}};
      end
      default: aligned = (addr_i[1:0] == 2'b00);
    endcase
  end

  assign accept       = (state_q == ST_IDLE) && data_req_i && aligned;
  assign misaligned_o = (state_q == ST_IDLE) && data_req_i && !aligned;

  // Move the addressed lane down to bit 0, then extend from the access width.
  assign shifted = mem_rdata_i >> {off_q, 3'b000};

  always_comb begin
    case (size_q)
      2'b00:   load_ext = {{(XLEN-8){~zext_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_ext = {{(XLEN-16){~zext_q & shifted[15]}}, shifted[15:0]};
      default: load_ext = mem_rdata_i;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_REQ;
      ST_REQ:  if (mem_gnt_i) state_d = wr_q ? ST_DONE : ST_RESP;
      ST_RESP: if (mem_rvalid_i) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      off_q     <= '0;
      size_q    <= '0;
      wr_q      <= 1'b0;
      zext_q    <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        off_q   <= addr_i[1:0];
        size_q  <= data_byte_i;
        wr_q    <= data_wr_i;
        zext_q  <= zero_extnd_i;
        addr_q  <= {addr_i[ADDR_W-1:2], 2'b00};
        be_q    <= be_d;
        wdata_q <= wdata_d;
      end
      if ((state_q == ST_RESP) && mem_rvalid_i) rd_data_q <= load_ext;
    end
  end

  assign mem_req_o   = (state_q == ST_REQ);
  assign mem_we_o    = wr_q;
  assign mem_addr_o  = addr_q;
  assign mem_be_o    = be_q;
  assign mem_wdata_o = wdata_q;
  assign stall_o     = accept || (state_q == ST_REQ) || (state_q == ST_RESP);
  assign rd_valid_o  = (state_q == ST_DONE);
  assign rd_data_o   = rd_data_q;

endmodule

// File: doc/yarp_lsu.md
# yarp_lsu

Load/store unit for the YARP core, sitting directly downstream of the control unit and ALU. It consumes the data-memory control outputs (`data_req`, `data_byte`, `data_wr`, `zero_extnd`), the ALU result as address and rs2 as store data. It runs a req/gnt/rvalid transaction with data memory and stalls the core until the access completes. It returns a sign- or zero-extended load result for the register-file write mux (MEM select).

## Interface
- `ADDR_W`, 32, address width; byte address.
- `XLEN`, 32, data width; only 32 supported.

- `clk`  in  1  core clock; all state on rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `data_req_i`  in  1  instruction needs a memory access; held stable while `stall_o`=1.
- `data_byte_i`  in  2  access size: 2'b00 BYTE, 2'b01 HALF_WORD, 2'b11 WORD; 2'b10 treated as WORD.
- `data_wr_i`  in  1  1 = store, 0 = load.
- `zero_extnd_i`  in  1  load result zero-extended when 1, sign-extended when 0.
- `addr_i`  in  ADDR_W  byte address (ALU result).
- `wr_data_i`  in  XLEN  store data (rs2), right-aligned.
- `mem_req_o`  out  1  memory request valid.
- `mem_we_o`  out  1  write enable.
- `mem_addr_o`  out  ADDR_W  word-aligned address, with `[1:0]`=0.
- `mem_be_o`  out  4  byte enables.
- `mem_wdata_o`  out  XLEN  lane-replicated store data.
- `mem_gnt_i`  in  1  request accepted this cycle.
- `mem_rvalid_i`  in  1  read data valid; never earlier than the cycle after `gnt`.
- `mem_rdata_i`  in  XLEN  read word.
- `stall_o`  out  1  core must not advance PC or write the register file.
- `rd_valid_o`  out  1  one-cycle pulse: access complete.
- `rd_data_o`  out  XLEN  extended load result; valid when `rd_valid_o`=1.
- `misaligned_o`  out  1  one-cycle pulse: access rejected as misaligned.

## Operation
- FSM states: IDLE, REQ, RESP, DONE. Reset state is IDLE.
- Alignment check:
  - HALF_WORD is misaligned when `addr_i[0]`=1.
  - WORD is misaligned when `addr_i[1:0]`≠0.
  - BYTE is never misaligned.
- **IDLE**
  - `data_req_i`=1 and aligned:
    - `stall_o`=1 combinationally.
    - Register `addr[1:0]`, size, `wr`, `zext`, word address, BE and write data.
    - Next state REQ.
  - `data_req_i`=1 and misaligned:
    - `misaligned_o`=1 for that cycle.
    - No memory request and no stall.
    - Remain in IDLE.
- **REQ**
  - `mem_req_o`=1; all `mem_*` outputs driven from registers and held stable until `gnt`.
  - On `mem_gnt_i`: a store goes to DONE; a load goes to RESP.
- **RESP**
  - `mem_req_o`=0.
  - On `mem_rvalid_i`: register the extracted, extended data into `rd_data_o`, then go to DONE.
- **DONE**
  - `stall_o`=0 and `rd_valid_o`=1; the core retires the instruction this cycle.
  - Always returns to IDLE; a request is never accepted in DONE.
- `stall_o` = (IDLE & `data_req_i` & aligned) | REQ | RESP.
- Byte enables:
  - BYTE: 4'b0001 << `addr[1:0]`.
  - HALF_WORD: 4'b0011 << {`addr[1]`,1'b0}.
  - WORD: 4'b1111.
- Store data:
  - BYTE: {4{`wr_data[7:0]`}}.
  - HALF_WORD: {2{`wr_data[15:0]`}}.
  - WORD: `wr_data` unchanged.
- Load extraction: shift = `mem_rdata_i` >> (8·`addr[1:0]`).
  - BYTE: take `shift[7:0]`, extend from bit 7.
  - HALF_WORD: take `shift[15:0]`, extend from bit 15.
  - WORD: full word, no extension.
  - Extension is zero fill when `zext`=1, else sign fill.
- `rd_data_o` holds its value until the next load completes; stores do not modify it.
- `mem_rvalid_i` outside RESP and `mem_gnt_i` outside REQ are ignored.

## Timing
- Reset values:
  - state IDLE.
  - `mem_req_o`, `mem_we_o`, `stall_o`, `rd_valid_o`, `misaligned_o` = 0.
  - `mem_addr_o`, `mem_be_o`, `mem_wdata_o`, `rd_data_o` = 0.
- Best-case load is 4 cycles, accept to retire: IDLE(accept) → REQ(gnt) → RESP(rvalid) → DONE.
- Best-case store is 3 cycles: IDLE → REQ(gnt) → DONE.
- Each cycle without `gnt` adds one cycle in REQ; each cycle without `rvalid` adds one cycle in RESP. There is no timeout.
- `mem_req_o` is registered-state driven only, with no combinational path from `data_req_i`.
- Reset asserted mid-transaction:
  - Immediate return to IDLE.
  - `mem_req_o` and `stall_o` drop asynchronously.
  - A later `rvalid` is ignored.
- Back-to-back memory instructions: the second is accepted in the IDLE cycle following DONE.

## Test plan
- **LW:** `addr`=0x100, `gnt` in first REQ cycle, `rvalid` one cycle later with rdata=0xDEADBEEF → `mem_addr_o`=0x100, `mem_be_o`=4'b1111, `stall_o` high 3 cycles, DONE `rd_data_o`=0xDEADBEEF, `rd_valid_o` one cycle.
- **LB vs LBU:** `addr`=0x103, rdata=0x80FF_1234 → `be`=4'b1000; LB gives 0xFFFFFF80, LBU gives 0x00000080.
- **SH:** `addr`=0x202, `wr_data`=0x0000ABCD, `gnt` held low 3 cycles → `mem_req_o` steady 4 cycles, `we`=1, `be`=4'b1100, `wdata`=0xABCDABCD, `addr`=0x200; DONE one cycle after `gnt`.
- **Misaligned:** LW at `addr`=0x101 → `misaligned_o`=1 one cycle, `mem_req_o`=0, `stall_o`=0; SH at 0x203 → same.
- **Reset mid-access:** drop `reset_n` while in RESP, then send `rvalid` after release → outputs return to 0, no `rd_valid_o` pulse.
- **Back-to-back:** SB 0x300 then LHU 0x302 with rdata=0x8001_0000 → SB `be`=4'b0001, then LHU accepted the cycle after DONE, `rd_data_o`=0x00008001.
